// File: rtl/mod_exp_engine.sv
// Fixed-latency right-to-left modular exponentiation engine.
// Two interleaved MSB-first modular multipliers share each multiplier bit.
module mod_exp_engine #(
    parameter int WIDTH = 128
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2*WIDTH-1:0] base,
    input  logic [2*WIDTH-1:0] exponent,
    input  logic [2*WIDTH-1:0] modulus,
    output logic [2*WIDTH-1:0] result,
    output logic               finish,
    output logic               error
);
    localparam int N  = 2 * WIDTH;
    localparam int KW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_NEXT,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [N-1:0]  r_b;
    logic [N-1:0]  r_e;
    logic [N-1:0]  r_m;
    logic [N-1:0]  r_r;
    logic [N:0]    r_pr;
    logic [N:0]    r_ps;
    logic [KW-1:0] r_k;
    logic [KW-1:0] r_cnt;
    logic [N-1:0]  r_result;
    logic          r_finish;
    logic          r_error;

    logic [N:0]    w_m;
    logic          w_mbit;
    logic [N:0]    w_pr_nxt;
    logic [N:0]    w_ps_nxt;
    logic [N-1:0]  w_r_nxt;

    // One interleaved step: P = 2P, reduce, add multiplicand, reduce.
    function automatic logic [N:0] mm_step(
        input logic [N:0] p,
        input logic [N:0] a,
        input logic       b,
        input logic [N:0] m
    );
        logic [N:0] t;
        t = {p[N-1:0], 1'b0};
        if (t >= m) t = t - m;
        if (b) t = t + a;
        if (t >= m) t = t - m;
        return t;
    endfunction

    always_comb begin
        w_m      = {1'b0, r_m};
        w_mbit   = r_b[r_k];
        w_pr_nxt = mm_step(r_pr, {1'b0, r_r}, w_mbit, w_m);
        w_ps_nxt = mm_step(r_ps, {1'b0, r_b}, w_mbit, w_m);
        w_r_nxt  = r_e[0] ? r_pr[N-1:0] : r_r;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_b      <= '0;
            r_e      <= '0;
            r_m      <= '0;
            r_r      <= '0;
            r_pr     <= '0;
            r_ps     <= '0;
            r_k      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_finish <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_b      <= base;
                        r_e      <= exponent;
                        r_m      <= modulus;
                        r_r      <= (modulus == N'(1)) ? '0 : N'(1);
                        r_pr     <= '0;
                        r_ps     <= '0;
                        r_k      <= KW'(N - 1);
                        r_cnt    <= '0;
                        r_result <= '0;
                        if (modulus == '0) begin
                            r_state  <= S_DONE;
                            r_finish <= 1'b1;
                            r_error  <= 1'b1;
                        end else begin
                            r_state  <= S_MUL;
                            r_finish <= 1'b0;
                            r_error  <= 1'b0;
                        end
                    end
                end
                S_MUL: begin
                    r_pr <= w_pr_nxt;
                    r_ps <= w_ps_nxt;
                    r_k  <= r_k - KW'(1);
                    if (r_k == '0) r_state <= S_NEXT;
                end
                S_NEXT: begin
                    r_r   <= w_r_nxt;
                    r_b   <= r_ps[N-1:0];
                    r_e   <= r_e >> 1;
                    r_cnt <= r_cnt + KW'(1);
                    r_pr  <= '0;
                    r_ps  <= '0;
                    r_k   <= KW'(N - 1);
                    if (r_cnt == KW'(N - 1)) begin
                        r_state  <= S_DONE;
                        r_result <= w_r_nxt;
                        r_finish <= 1'b1;
                    end else begin
                        r_state <= S_MUL;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign result = r_result;
    assign finish = r_finish;
    assign error  = r_error;
endmodule

// File: tb/tb_mod_exp_engine.sv
// Directed bench for mod_exp_engine at WIDTH = 8 (16-bit operands).
// Vectors carry hand-computed results, error flags and latencies.
module tb_mod_exp_engine;
    localparam int WIDTH = 8;
    localparam int N     = 2 * WIDTH;
    localparam int LAT   = N * (N + 1);
    localparam int LIMIT = 400;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] base;
    logic [N-1:0] exponent;
    logic [N-1:0] modulus;
    logic [N-1:0] result;
    logic         finish;
    logic         error;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [N-1:0] b;
        logic [N-1:0] e;
        logic [N-1:0] m;
        logic [N-1:0] res;
        logic         err;
        int           lat;
    } vec_t;

    vec_t vecs[9];

    mod_exp_engine #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .base     (base),
        .exponent (exponent),
        .modulus  (modulus),
        .result   (result),
        .finish   (finish),
        .error    (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one edge; returns after that edge with start low.
    task automatic pulse_start(input logic [N-1:0] b, input logic [N-1:0] e,
                               input logic [N-1:0] m);
        base     = b;
        exponent = e;
        modulus  = m;
        start    = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_finish(output int lat);
        lat = 0;
        while (!finish && lat < LIMIT) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int lat;
        pulse_start(v.b, v.e, v.m);
        if (v.lat > 0) check({name, " finish low after start"}, int'(finish), 0);
        wait_finish(lat);
        check({name, " latency"}, lat, v.lat);
        check({name, " result"}, int'(result), int'(v.res));
        check({name, " error"}, int'(error), int'(v.err));
    endtask

    initial begin
        int lat;
        vecs[0] = '{b: 4,    e: 13,   m: 497,  res: 445,  err: 0, lat: LAT};
        vecs[1] = '{b: 65,   e: 17,   m: 3233, res: 2790, err: 0, lat: LAT};
        vecs[2] = '{b: 2790, e: 2753, m: 3233, res: 65,   err: 0, lat: LAT};
        vecs[3] = '{b: 123,  e: 0,    m: 3233, res: 1,    err: 0, lat: LAT};
        vecs[4] = '{b: 0,    e: 5,    m: 1,    res: 0,    err: 0, lat: LAT};
        vecs[5] = '{b: 2,    e: 10,   m: 1000, res: 24,   err: 0, lat: LAT};
        vecs[6] = '{b: 3,    e: 4,    m: 5,    res: 1,    err: 0, lat: LAT};
        vecs[7] = '{b: 7,    e: 3,    m: 0,    res: 0,    err: 1, lat: 0};
        vecs[8] = '{b: 4,    e: 13,   m: 497,  res: 445,  err: 0, lat: LAT};

        reset    = 1'b1;
        start    = 1'b0;
        base     = '0;
        exponent = '0;
        modulus  = '0;
        tick();
        tick();
        check("reset result", int'(result), 0);
        check("reset finish", int'(finish), 0);
        check("reset error", int'(error), 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Start pulses and input changes while busy are ignored.
        pulse_start(4, 13, 497);
        lat = 0;
        while (!finish && lat < LIMIT) begin
            if (lat == 9 || lat == 99) begin
                base     = 100;
                exponent = 7;
                modulus  = 211;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        check("busy-start latency", lat, LAT);
        check("busy-start result", int'(result), 445);

        // Reset mid-operation aborts with no finish pulse.
        pulse_start(65, 17, 3233);
        for (int i = 1; i < 50; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort result", int'(result), 0);
        lat = 0;
        for (int i = 0; i < LAT + 20; i++) begin
            if (finish) lat++;
            tick();
        end
        check("abort no finish", lat, 0);

        // Reset wins over start on the same edge.
        base     = 4;
        exponent = 13;
        modulus  = 0;
        start    = 1'b1;
        reset    = 1'b1;
        tick();
        start = 1'b0;
        reset = 1'b0;
        tick();
        check("reset-priority finish", int'(finish), 0);
        check("reset-priority error", int'(error), 0);

        run_vec("post-reset", vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mod_exp_engine.md
MOD_EXP_ENGINE -- requirements
Module: mod_exp_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 128; operands and result are 2*WIDTH bits wide, matching the control message width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, with all state updated on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: a one-cycle request, sampled only in IDLE or DONE.
REQ-005 SHALL have port base, input, 2*WIDTH bits: the message or ciphertext; precondition base < modulus.
REQ-006 SHALL have port exponent, input, 2*WIDTH bits: the public or private exponent (e or d).
REQ-007 SHALL have port modulus, input, 2*WIDTH bits: n = p*q.
REQ-008 SHALL have port result, output, 2*WIDTH bits: base^exponent mod modulus.
REQ-009 SHALL have port finish, output, 1 bit: high while result is valid.
REQ-010 SHALL have port error, output, 1 bit: high when the last accepted request had modulus == 0.

Function
REQ-011 SHALL implement states IDLE, MUL, NEXT and DONE.
REQ-012 On a start edge in IDLE or DONE, the block SHALL:
- capture base into B, exponent into E and modulus into M;
- set R = (modulus == 1) ? 0 : 1;
- clear the bit counter and set multiplier index k = 2*WIDTH-1;
- drop finish and error;
- go to MUL.
REQ-013 If modulus == 0 at start, the block SHALL go directly to DONE on the same edge with result = 0, error = 1 and finish = 1.
REQ-014 MUL SHALL run two MSB-first interleaved modular multiplications in parallel, Pr = R*B and Ps = B*B, one multiplier bit per cycle: P = 2P, subtract M if P >= M, add the multiplicand if the multiplier bit is set, subtract M if P >= M.
REQ-015 Internal accumulators SHALL be 2*WIDTH+1 bits wide so that no intermediate sum overflows.
REQ-016 After exactly 2*WIDTH MUL cycles (k reaches 0), the block SHALL go to NEXT.
REQ-017 In NEXT, the block SHALL:
- set R = Pr if E[0] is 1, otherwise leave R unchanged;
- set B = Ps;
- shift E right by 1 and increment the bit counter;
- go to DONE if the counter was 2*WIDTH-1, otherwise return to MUL with k reset.
REQ-018 Latency SHALL be fixed and data-independent: finish rises on edge 2*WIDTH*(2*WIDTH+1) counting the start edge as edge 0; leading zero exponent bits are never skipped.
REQ-019 In DONE, result SHALL equal R, and finish and result SHALL hold until the next accepted start or reset.
REQ-020 A start pulse in MUL or NEXT SHALL be ignored with no effect on the running operation or its inputs.
REQ-021 Input ports SHALL be sampled only on the start edge; changes while busy SHALL have no effect.
REQ-022 A start arriving in DONE SHALL begin a new operation on that edge, and finish SHALL fall on that same edge.
REQ-023 If base >= modulus, result is unspecified, but finish SHALL still assert at the REQ-018 latency.
REQ-024 exponent == 0 with modulus > 1 SHALL give result 1.
REQ-025 modulus == 1 SHALL give result 0.

Reset
REQ-026 A reset edge SHALL force IDLE, result = 0, finish = 0, error = 0, and clear all counters and internal registers, in any state.
REQ-027 Reset SHALL take priority over start on the same edge.
REQ-028 Reset in the middle of an operation SHALL abort it; no finish pulse SHALL follow.

Verification (WIDTH = 8, 16-bit operands, latency 272 cycles)
REQ-029 base = 4, exponent = 13, modulus = 497, start -> finish rises exactly 272 edges after start, result = 445, error = 0.
REQ-030 RSA round trip with n = 3233:
- base = 65, exponent = 17 -> result = 2790;
- then start with base = 2790, exponent = 2753 -> result = 65.
REQ-031 Boundary cases:
- exponent = 0, modulus = 3233, base = 123 -> result = 1;
- modulus = 1, base = 0, exponent = 5 -> result = 0;
- each at latency 272.
REQ-032 modulus = 0 -> finish = 1 and error = 1 on the edge after start, result = 0.
REQ-033 Start pulses at edges 10 and 100 while busy -> ignored; result still 445 at edge 272 for the REQ-029 inputs.
REQ-034 Reset asserted at edge 50 of an operation -> finish stays 0; a fresh start afterwards gives correct results.
